// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard unit.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
    } pend_entry_t;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/hazard_src_cmp.sv
// Compares one decoded source operand against one in-flight load destination.
module hazard_src_cmp #(
    parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] src_reg,
    input  logic                  src_used,
    input  logic                  cand_valid,
    input  logic [REG_ADDR_W-1:0] cand_rd,
    output logic                  match
);

    // $0 is hardwired to zero, so a load targeting it can never feed a consumer.
    assign match = src_used && cand_valid
                && (src_reg != REG_ADDR_W'(hazard_pkg::ZERO_REG))
                && (src_reg == cand_rd);

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard unit: stalls IF/ID while a source register waits on a load
// that is in EX or still within LOAD_LAT-1 cycles of leaving it.
module load_hazard_scoreboard #(
    parameter int REG_ADDR_W  = hazard_pkg::REG_ADDR_W,
    parameter int NUM_SRC     = 2,
    parameter int LOAD_LAT    = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              idex_valid,
    input  logic                              idex_memread,
    input  logic [REG_ADDR_W-1:0]             idex_reg_rt,
    input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] ifid_src_reg,
    input  logic [NUM_SRC-1:0]                ifid_src_used,
    input  logic                              ifid_flush,
    input  logic                              pipe_freeze,
    input  logic                              stall_cnt_clr,
    output logic                              hazard_detected,
    output logic                              pc_write_en,
    output logic                              ifid_write_en,
    output logic                              idex_bubble,
    output logic [STALL_CNT_W-1:0]            stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
    } cand_t;

    // cand[0] is the load currently in EX; cand[k] is the load that was in EX k cycles ago.
    cand_t [LOAD_LAT-1:0]              cand;
    logic  [NUM_SRC-1:0][LOAD_LAT-1:0] match;

    assign cand[0] = {idex_valid & idex_memread, idex_reg_rt};

    generate
        if (LOAD_LAT > 1) begin : g_pend
            cand_t [LOAD_LAT-1:1] pend;

            // NOTE: state is written with non-blocking assignments so every entry
            // shifts from its pre-edge neighbour, independent of statement order.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend <= '0;
                end else if (!pipe_freeze) begin
                    pend <= cand[LOAD_LAT-2:0];
                end
            end

            assign cand[LOAD_LAT-1:1] = pend;
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            for (genvar c = 0; c < LOAD_LAT; c++) begin : g_cand
                hazard_src_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp (
                    .src_reg    (ifid_src_reg[i]),
                    .src_used   (ifid_src_used[i]),
                    .cand_valid (cand[c].valid),
                    .cand_rd    (cand[c].rd),
                    .match      (match[i][c])
                );
            end
        end
    endgenerate

    assign hazard_detected = (|match) & ~ifid_flush;
    assign pc_write_en     = ~hazard_detected;
    assign ifid_write_en   = ~hazard_detected;
    assign idex_bubble     = hazard_detected;

    // Frozen cycles are not counted: the pipeline would have stalled regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall_cnt_clr) begin
            stall_count <= '0;
        end else if (hazard_detected && !pipe_freeze && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule
